// File: rtl/cache_domain_driver_pkg.sv
//==============================================================================
// Module      : cache_domain_driver_pkg
// Description : Shared constants for the domain driver: way/address widths
//               from the cacheline constants, domain count, FSM encodings.
// Revision    : 1.0
//==============================================================================
`default_nettype none

`ifndef NUM_WAYS
`define NUM_WAYS 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package cache_domain_driver_pkg;
    localparam int c_num_ways    = `NUM_WAYS;
    localparam int c_addr_width  = `ADDR_WIDTH;
    localparam int c_num_domains = 2;

    localparam int              c_state_w   = 2;
    localparam logic [1:0]      c_st_idle   = 2'd0;
    localparam logic [1:0]      c_st_switch = 2'd1;
    localparam logic [1:0]      c_st_access = 2'd2;
    localparam logic [1:0]      c_st_resp   = 2'd3;
endpackage

`default_nettype wire

// File: rtl/cache_domain_arbiter.sv
//==============================================================================
// Module      : cache_domain_arbiter
// Description : Two-domain grant with a run-length quantum so a busy domain
//               cannot starve the other one.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module cache_domain_arbiter #(
    parameter int QUANTUM = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_arb_en,
    input  logic i_d0_valid,
    input  logic i_d1_valid,
    input  logic i_cur_dom,
    input  logic i_dom_loaded,
    output logic o_grant_valid,
    output logic o_grant_dom
);
    localparam int                 c_run_w   = $clog2(QUANTUM + 1);
    localparam logic [c_run_w-1:0] c_quantum = c_run_w'(QUANTUM);

    logic [c_run_w-1:0] r_run_cnt;

    always_comb begin
        o_grant_valid = i_arb_en && (i_d0_valid || i_d1_valid);
        o_grant_dom   = i_d1_valid;
        if (i_d0_valid && i_d1_valid) begin
            if (!i_dom_loaded)
                o_grant_dom = 1'b0;
            else if (r_run_cnt == c_quantum)
                o_grant_dom = ~i_cur_dom;
            else
                o_grant_dom = i_cur_dom;
        end
    end

    // Saturates at QUANTUM so a long solo run still yields at once when contended.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_run_cnt <= '0;
        end else if (o_grant_valid) begin
            if (o_grant_dom != i_cur_dom)
                r_run_cnt <= c_run_w'(1);
            else if (r_run_cnt != c_quantum)
                r_run_cnt <= r_run_cnt + 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/cache_domain_driver.sv
//==============================================================================
// Module      : cache_domain_driver
// Description : Request-side driver for the partitioned PLRU cacheline; inserts
//               domain switches, returns hit/miss and keeps per-domain stats.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module cache_domain_driver
    import cache_domain_driver_pkg::*;
#(
    parameter int NUM_WAYS   = c_num_ways,
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int QUANTUM    = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic                  cfg_dom,
    input  logic [NUM_WAYS-1:0]   cfg_hitmap,
    input  logic                  d0_valid,
    input  logic [ADDR_WIDTH-1:0] d0_addr,
    output logic                  d0_ready,
    input  logic                  d1_valid,
    input  logic [ADDR_WIDTH-1:0] d1_addr,
    output logic                  d1_ready,
    output logic                  os_req,
    output logic [NUM_WAYS-1:0]   hitmap,
    output logic                  user_req,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic                  hit,
    output logic                  rsp_valid,
    output logic                  rsp_dom,
    output logic                  rsp_hit,
    input  logic                  stat_dom,
    output logic [CNT_W-1:0]      stat_hits,
    output logic [CNT_W-1:0]      stat_misses
);
    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_state_nxt;
    logic                  r_g;
    logic                  r_cur_dom;
    logic                  r_dom_loaded;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NUM_WAYS-1:0]   r_hitmap_reg [c_num_domains];
    logic [CNT_W-1:0]      r_hits       [c_num_domains];
    logic [CNT_W-1:0]      r_misses     [c_num_domains];

    logic w_arb_en;
    logic w_grant_valid;
    logic w_grant_dom;
    logic w_eff_dom;
    logic w_cfg_unload;

    assign w_arb_en = (r_state == c_st_idle) && reset;

    cache_domain_arbiter #(
        .QUANTUM (QUANTUM)
    ) u_arbiter (
        .clk           (clk),
        .reset         (reset),
        .i_arb_en      (w_arb_en),
        .i_d0_valid    (d0_valid),
        .i_d1_valid    (d1_valid),
        .i_cur_dom     (r_cur_dom),
        .i_dom_loaded  (r_dom_loaded),
        .o_grant_valid (w_grant_valid),
        .o_grant_dom   (w_grant_dom)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_grant_valid)
                    w_state_nxt = (!r_dom_loaded || (w_grant_dom != r_cur_dom)) ? c_st_switch : c_st_access;
            end
            c_st_switch: w_state_nxt = c_st_access;
            c_st_access: w_state_nxt = c_st_resp;
            c_st_resp:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    assign d0_ready    = w_grant_valid && !w_grant_dom;
    assign d1_ready    = w_grant_valid &&  w_grant_dom;
    assign os_req      = (r_state == c_st_switch);
    assign hitmap      = os_req ? r_hitmap_reg[r_g] : '0;
    assign user_req    = (r_state == c_st_access);
    assign addr        = r_addr;
    assign rsp_valid   = (r_state == c_st_resp);
    assign rsp_dom     = rsp_valid && r_g;
    assign rsp_hit     = rsp_valid && hit;
    assign stat_hits   = r_hits[stat_dom];
    assign stat_misses = r_misses[stat_dom];

    // During SWITCH the domain being loaded is the one a config write can invalidate.
    assign w_eff_dom    = (r_state == c_st_switch) ? r_g : r_cur_dom;
    assign w_cfg_unload = cfg_we && (cfg_dom == w_eff_dom);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_st_idle;
            r_g          <= 1'b0;
            r_cur_dom    <= 1'b0;
            r_dom_loaded <= 1'b0;
            r_addr       <= '0;
            for (int i = 0; i < c_num_domains; i++) begin
                r_hitmap_reg[i] <= '0;
                r_hits[i]       <= '0;
                r_misses[i]     <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_valid) begin
                r_g    <= w_grant_dom;
                r_addr <= w_grant_dom ? d1_addr : d0_addr;
            end
            if (r_state == c_st_switch)
                r_cur_dom <= r_g;
            if (cfg_we)
                r_hitmap_reg[cfg_dom] <= cfg_hitmap;
            if (w_cfg_unload)
                r_dom_loaded <= 1'b0;
            else if (r_state == c_st_switch)
                r_dom_loaded <= 1'b1;
            if (rsp_valid) begin
                if (hit) begin
                    if (r_hits[r_g] != '1)
                        r_hits[r_g] <= r_hits[r_g] + 1'b1;
                end else begin
                    if (r_misses[r_g] != '1)
                        r_misses[r_g] <= r_misses[r_g] + 1'b1;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cache_domain_driver.sv
//==============================================================================
// Module      : tb_cache_domain_driver
// Description : Directed self-checking bench with a small partitioned cacheline
//               model supplying the registered hit input.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_cache_domain_driver;
    import cache_domain_driver_pkg::*;

    localparam int NW = c_num_ways;
    localparam int AW = c_addr_width;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we, cfg_dom;
    logic [NW-1:0] cfg_hitmap;
    logic          d0_valid, d1_valid;
    logic [AW-1:0] d0_addr, d1_addr;
    logic          d0_ready, d1_ready;
    logic          os_req, user_req, rsp_valid, rsp_dom, rsp_hit;
    logic [NW-1:0] hitmap;
    logic [AW-1:0] addr;
    logic          hit;
    logic          stat_dom;
    logic [15:0]   stat_hits, stat_misses;

    logic          s_d0_ready, s_d1_ready, s_os_req, s_user_req, s_rsp_valid, s_rsp_dom, s_rsp_hit;
    logic [NW-1:0] s_hitmap;
    logic [AW-1:0] s_addr;
    logic [3:0]    s_stat_hits, s_stat_misses;

    int compared = 0;
    int failed   = 0;

    always #5 clk = ~clk;

    cache_domain_driver dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_dom(cfg_dom), .cfg_hitmap(cfg_hitmap),
        .d0_valid(d0_valid), .d0_addr(d0_addr), .d0_ready(d0_ready),
        .d1_valid(d1_valid), .d1_addr(d1_addr), .d1_ready(d1_ready),
        .os_req(os_req), .hitmap(hitmap), .user_req(user_req), .addr(addr), .hit(hit),
        .rsp_valid(rsp_valid), .rsp_dom(rsp_dom), .rsp_hit(rsp_hit),
        .stat_dom(stat_dom), .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    // Narrow-counter copy sharing all inputs, used to reach saturation quickly.
    cache_domain_driver #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_dom(cfg_dom), .cfg_hitmap(cfg_hitmap),
        .d0_valid(d0_valid), .d0_addr(d0_addr), .d0_ready(s_d0_ready),
        .d1_valid(d1_valid), .d1_addr(d1_addr), .d1_ready(s_d1_ready),
        .os_req(s_os_req), .hitmap(s_hitmap), .user_req(s_user_req), .addr(s_addr), .hit(hit),
        .rsp_valid(s_rsp_valid), .rsp_dom(s_rsp_dom), .rsp_hit(s_rsp_hit),
        .stat_dom(stat_dom), .stat_hits(s_stat_hits), .stat_misses(s_stat_misses)
    );

    // Cacheline model: lookup restricted to the loaded partition, fill lowest free way.
    logic [AW-1:0] m_tag [NW];
    logic [NW-1:0] m_vld, m_mask;
    logic          m_h;
    int            m_fi, m_fl;

    always @(posedge clk) begin
        if (!reset) begin
            m_vld  <= '0;
            m_mask <= '0;
            hit    <= 1'b0;
        end else begin
            if (os_req) m_mask <= hitmap;
            hit <= 1'b0;
            if (user_req) begin
                m_h = 1'b0; m_fi = -1; m_fl = -1;
                for (int w = NW - 1; w >= 0; w--) begin
                    if (m_mask[w] && m_vld[w] && m_tag[w] == addr) m_h = 1'b1;
                    if (m_mask[w] && !m_vld[w]) m_fi = w;
                    if (m_mask[w]) m_fl = w;
                end
                if (!m_h && m_fl >= 0) begin
                    m_tag[(m_fi >= 0) ? m_fi : m_fl] <= addr;
                    m_vld[(m_fi >= 0) ? m_fi : m_fl] <= 1'b1;
                end
                hit <= m_h;
            end
        end
    end

    logic mon_en = 1'b0;
    int   grant_q[$];
    int   osreq_cnt;
    always @(negedge clk) begin
        if (mon_en) begin
            if (d0_ready) grant_q.push_back(0);
            if (d1_ready) grant_q.push_back(1);
            if (os_req) osreq_cnt++;
        end
    end

    task automatic apply_reset();
        reset = 1'b0; d0_valid = 1'b0; d1_valid = 1'b0; cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic dom, input logic [NW-1:0] map);
        cfg_we = 1'b1; cfg_dom = dom; cfg_hitmap = map;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic do_access(input logic dom, input logic [AW-1:0] a, input logic exp_sw,
                             input logic [NW-1:0] exp_map, input logic exp_hit, input string nm);
        int   n;
        logic rdy;
        if (dom) begin d1_valid = 1'b1; d1_addr = a; end
        else     begin d0_valid = 1'b1; d0_addr = a; end
        #1;
        rdy = dom ? d1_ready : d0_ready;
        n = 0;
        while (!rdy && n < 10) begin
            @(posedge clk); #2;
            rdy = dom ? d1_ready : d0_ready;
            n++;
        end
        compared++;
        if (rdy !== 1'b1) begin
            failed++;
            $display("FAIL %s grant: ready=%b after %0d cycles, required 1", nm, rdy, n);
        end
        @(posedge clk); #1;
        d0_valid = 1'b0; d1_valid = 1'b0;
        #1;
        if (exp_sw) begin
            compared++;
            if (os_req !== 1'b1 || hitmap !== exp_map || user_req !== 1'b0) begin
                failed++;
                $display("FAIL %s switch: os_req=%b hitmap=%h user_req=%b, required 1 %h 0",
                         nm, os_req, hitmap, user_req, exp_map);
            end
            @(posedge clk); #2;
        end else begin
            compared++;
            if (os_req !== 1'b0) begin
                failed++;
                $display("FAIL %s no_switch: os_req=%b, required 0", nm, os_req);
            end
        end
        compared++;
        if (user_req !== 1'b1 || addr !== a) begin
            failed++;
            $display("FAIL %s access: user_req=%b addr=%h, required 1 %h", nm, user_req, addr, a);
        end
        @(posedge clk); #2;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_dom !== dom || rsp_hit !== exp_hit) begin
            failed++;
            $display("FAIL %s rsp: valid=%b dom=%b hit=%b, required 1 %b %b",
                     nm, rsp_valid, rsp_dom, rsp_hit, dom, exp_hit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        stat_dom = 1'b0;
        d0_valid = 1'b1; d0_addr = 16'h0001;
        #1;
        compared++;
        if ({os_req, user_req, rsp_valid, rsp_dom, rsp_hit, d0_ready, d1_ready} !== 7'b0 ||
            hitmap !== '0 || addr !== '0) begin
            failed++;
            $display("FAIL reset_outputs: os=%b ur=%b rv=%b rd=%b rh=%b r0=%b r1=%b map=%h addr=%h, required all 0",
                     os_req, user_req, rsp_valid, rsp_dom, rsp_hit, d0_ready, d1_ready, hitmap, addr);
        end
        for (int d = 0; d < 2; d++) begin
            stat_dom = d[0];
            #1;
            compared++;
            if (stat_hits !== 16'd0 || stat_misses !== 16'd0) begin
                failed++;
                $display("FAIL reset_stats dom%0d: hits=%0d misses=%0d, required 0 0", d, stat_hits, stat_misses);
            end
        end
        d0_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_first_miss();
        cfg_write(1'b0, 8'h0F);
        cfg_write(1'b1, 8'hF0);
        do_access(1'b0, 16'h0005, 1'b1, 8'h0F, 1'b0, "first_miss");
        stat_dom = 1'b0; #1;
        compared++;
        if (stat_misses !== 16'd1 || stat_hits !== 16'd0) begin
            failed++;
            $display("FAIL first_miss_stats: misses=%0d hits=%0d, required 1 0", stat_misses, stat_hits);
        end
    endtask

    task automatic test_same_domain_hit();
        do_access(1'b0, 16'h0005, 1'b0, 8'h00, 1'b1, "same_dom_hit");
        stat_dom = 1'b0; #1;
        compared++;
        if (stat_hits !== 16'd1) begin
            failed++;
            $display("FAIL same_dom_stats: hits=%0d, required 1", stat_hits);
        end
    endtask

    task automatic test_isolation();
        do_access(1'b1, 16'h0005, 1'b1, 8'hF0, 1'b0, "isolation");
        stat_dom = 1'b1; #1;
        compared++;
        if (stat_misses !== 16'd1 || stat_hits !== 16'd0) begin
            failed++;
            $display("FAIL isolation_stats: misses=%0d hits=%0d, required 1 0", stat_misses, stat_hits);
        end
    endtask

    task automatic test_cfg_reload();
        // Ways 0..1 include way 0, which holds domain 0's fill of address 5.
        cfg_write(1'b1, 8'h03);
        do_access(1'b1, 16'h0005, 1'b1, 8'h03, 1'b1, "cfg_reload");
        cfg_write(1'b0, 8'h0F);
        do_access(1'b1, 16'h0005, 1'b0, 8'h00, 1'b1, "cfg_other_dom");
    endtask

    task automatic test_quantum();
        int exp_q[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        int n;
        apply_reset();
        reset = 1'b1;
        cfg_write(1'b0, 8'h0F);
        cfg_write(1'b1, 8'hF0);
        grant_q.delete();
        osreq_cnt = 0;
        mon_en = 1'b1;
        d0_valid = 1'b1; d0_addr = 16'h0010;
        d1_valid = 1'b1; d1_addr = 16'h0020;
        n = 0;
        while (grant_q.size() < 9 && n < 80) begin
            @(posedge clk); #1;
            n++;
        end
        d0_valid = 1'b0; d1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        mon_en = 1'b0;
        compared++;
        if (grant_q.size() !== 9) begin
            failed++;
            $display("FAIL quantum_count: grants=%0d, required 9", grant_q.size());
        end
        for (int i = 0; i < 9; i++) begin
            if (i < grant_q.size()) begin
                compared++;
                if (grant_q[i] !== exp_q[i]) begin
                    failed++;
                    $display("FAIL quantum_order[%0d]: dom=%0d, required %0d", i, grant_q[i], exp_q[i]);
                end
            end
        end
        compared++;
        if (osreq_cnt !== 3) begin
            failed++;
            $display("FAIL quantum_os_req: count=%0d, required 3", osreq_cnt);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        reset = 1'b1;
        cfg_write(1'b0, 8'h0F);
        do_access(1'b0, 16'h0030, 1'b1, 8'h0F, 1'b0, "sat_fill");
        for (int i = 0; i < 19; i++)
            do_access(1'b0, 16'h0030, 1'b0, 8'h00, 1'b1, "sat_hit");
        stat_dom = 1'b0; #1;
        compared++;
        if (stat_hits !== 16'd19 || stat_misses !== 16'd1) begin
            failed++;
            $display("FAIL sat_wide: hits=%0d misses=%0d, required 19 1", stat_hits, stat_misses);
        end
        compared++;
        if (s_stat_hits !== 4'hF || s_stat_misses !== 4'd1) begin
            failed++;
            $display("FAIL sat_narrow: hits=%0d misses=%0d, required 15 1", s_stat_hits, s_stat_misses);
        end
    endtask

    task automatic test_reset_in_access();
        d0_valid = 1'b1; d0_addr = 16'h0030;
        #1;
        compared++;
        if (d0_ready !== 1'b1) begin
            failed++;
            $display("FAIL rst_access_grant: ready=%b, required 1", d0_ready);
        end
        @(posedge clk); #1;
        d0_valid = 1'b0;
        compared++;
        if (user_req !== 1'b1) begin
            failed++;
            $display("FAIL rst_access_state: user_req=%b, required 1", user_req);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        stat_dom = 1'b0; #1;
        compared++;
        if (user_req !== 1'b0 || rsp_valid !== 1'b0 || os_req !== 1'b0 ||
            stat_hits !== 16'd0 || stat_misses !== 16'd0) begin
            failed++;
            $display("FAIL rst_access_abort: ur=%b rv=%b os=%b hits=%0d misses=%0d, required 0 0 0 0 0",
                     user_req, rsp_valid, os_req, stat_hits, stat_misses);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (rsp_valid !== 1'b0) begin
            failed++;
            $display("FAIL rst_access_no_rsp: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    initial begin
        reset = 1'b0; cfg_we = 1'b0; cfg_dom = 1'b0; cfg_hitmap = '0;
        d0_valid = 1'b0; d1_valid = 1'b0; d0_addr = '0; d1_addr = '0; stat_dom = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_first_miss();
        test_same_domain_hit();
        test_isolation();
        test_cfg_reload();
        test_quantum();
        test_saturation();
        test_reset_in_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire

// File: doc/cache_domain_driver.md
Name: cache_domain_driver

Overview:
- Request-side driver for the partitioned PLRU cacheline. It issues that block's os_req/hitmap and user_req/addr pins and consumes its registered hit output.
- Arbitrates access streams from two security domains. A domain switch (os_req carrying that domain's way partition) is inserted only when the granted domain differs from the one currently loaded.
- Returns a per-access hit/miss response and keeps saturating hit/miss statistics per domain.

Parameters:
NUM_WAYS, `NUM_WAYS (8), width of the way-partition hitmap.
ADDR_WIDTH, `ADDR_WIDTH, tag/address width.
QUANTUM, 4, maximum consecutive grants to one domain while the other domain is waiting.
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cfg_we  in  1  write a domain hitmap register
cfg_dom  in  1  domain index for cfg_we
cfg_hitmap  in  NUM_WAYS  way partition value to write
d0_valid  in  1  domain 0 request valid
d0_addr  in  ADDR_WIDTH  domain 0 address
d0_ready  out  1  domain 0 request accepted this cycle
d1_valid  in  1  domain 1 request valid
d1_addr  in  ADDR_WIDTH  domain 1 address
d1_ready  out  1  domain 1 request accepted this cycle
os_req  out  1  to cacheline: switch domain
hitmap  out  NUM_WAYS  to cacheline: partition value, meaningful only while os_req=1
user_req  out  1  to cacheline: access
addr  out  ADDR_WIDTH  to cacheline: access address
hit  in  1  from cacheline, registered there
rsp_valid  out  1  response strobe
rsp_dom  out  1  domain of the response
rsp_hit  out  1  1 = hit, 0 = miss (line filled)
stat_dom  in  1  statistics read select
stat_hits  out  CNT_W  hit count of stat_dom (combinational read)
stat_misses  out  CNT_W  miss count of stat_dom (combinational read)

Behaviour:
- Reset (reset=0 at a clk edge):
  - State IDLE; all outputs 0.
  - Both hitmap registers, all counters, cur_dom, dom_loaded and run_cnt cleared.
  - Reset always wins over any in-flight transaction, which is abandoned with no response.
- FSM states IDLE, SWITCH, ACCESS, RESP. os_req, user_req and rsp_valid are decoded from state only, so they never assert together.
- IDLE: arbitration.
  - If any request is valid, grant and pulse dN_ready for that cycle.
  - Latch the granted domain (g) and its address into addr.
  - If dom_loaded=0 or g!=cur_dom, go to SWITCH; otherwise go to ACCESS.
- Arbitration:
  - With one domain valid, grant it.
  - With both valid, grant cur_dom unless run_cnt==QUANTUM, in which case grant the other domain.
  - With both valid and dom_loaded=0, grant domain 0.
  - run_cnt increments on each grant to cur_dom and resets to 1 on a grant causing a domain change.
- SWITCH (1 cycle): os_req=1, hitmap=hitmap_reg[g]; set cur_dom<=g and dom_loaded<=1; go to ACCESS.
- ACCESS (1 cycle): user_req=1 with addr held; go to RESP.
- RESP (1 cycle):
  - rsp_valid=1, rsp_dom=g, rsp_hit=hit.
  - Increment the hit or miss counter of g, saturating at all-ones.
  - Go to IDLE.
- Latency from grant cycle T:
  - Same domain: user_req at T+1, rsp_valid at T+2.
  - Domain switch: os_req at T+1, user_req at T+2, rsp_valid at T+3.
- Throughput: one access per 3 cycles, or per 4 cycles with a switch. Only one access is ever in flight.
- Configuration:
  - cfg_we writes hitmap_reg[cfg_dom] in any state.
  - If cfg_dom==cur_dom, dom_loaded is cleared, forcing a fresh os_req before the next access to that domain.
  - A write in the SWITCH cycle to the same domain: the os_req uses the old value, and the clear of dom_loaded overrides the set.
  - An in-flight access completes under the old partition.
- Valid inputs are not required to stay stable after ready. The address is captured only at grant.
- A hitmap of all zeros is legal: every access then responds as a miss.

Decomposition:
- Shared header (alongside the cacheline constants): FSM state encodings and the NUM_DOMAINS=2 constant. NUM_WAYS and ADDR_WIDTH come from the existing constants header.
- One natural sub-module: cache_domain_arbiter, the combinational grant plus the run_cnt/QUANTUM tracking.

Test Plan:
- Reset, cfg hitmap d0=8'h0F, d1=8'hF0; d0 issues addr 5 -> os_req with hitmap 8'h0F at T+1, user_req at T+2, rsp_valid at T+3 with rsp_hit=0; stat_misses[d0]=1.
- d0 repeats addr 5 -> no os_req; user_req at T+1, rsp_valid at T+2 with rsp_hit=1; stat_hits[d0]=1.
- d1 issues addr 5 after d0 has filled it -> os_req with hitmap 8'hF0, then rsp_hit=0 (partition isolation).
- Both valid continuously with QUANTUM=4 -> grant order d0,d0,d0,d0,d1,d1,d1,d1,d0...; exactly one os_req per domain change.
- cfg_we to cur_dom with 8'h03 between accesses -> the next access to that domain is preceded by os_req with hitmap 8'h03.
- reset=0 asserted in the ACCESS state -> next cycle in IDLE, no rsp_valid, counters 0. Separately, force 2^CNT_W+3 hits -> stat_hits holds at all-ones.
